logic_gate_pipe: RTL

//  Parametrised, pipelined successor to the 2-input AND cell: reduces N_IN operands of WIDTH bits

---
 rtl/logic_gate_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipeline that reduces N_IN operands
// of WIDTH bits with a run-time selected bitwise operation
// (AND/OR/XOR/NAND/NOR/XNOR).
//
// Op codes 6 and 7 are reserved. A bundle that carries one of them produces
// out_data=0 with out_err=1. It still takes one slot and stays in order.
//
// Optional build macro LOGIC_GATE_PIPE_STATS_EN adds two 16-bit wrapping
// counters: stat_count (completed output transfers) and stat_err (completed
// transfers that had out_err=1).
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_err
`ifdef LOGIC_GATE_PIPE_STATS_EN
    ,
    output logic [15:0]            stat_count,
    output logic [15:0]            stat_err
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    // stage 1: captured bundle
    logic                  r_s1_valid;
    logic [N_IN*WIDTH-1:0] r_s1_data;
    logic [2:0]            r_s1_op;

    // stage 2: registered result (drives the output port directly)
    logic                  r_s2_valid;
    logic [WIDTH-1:0]      r_out_data;
    logic                  r_out_err;

    logic                  w_s2_load;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [WIDTH-1:0]      w_and;
    logic [WIDTH-1:0]      w_or;
    logic [WIDTH-1:0]      w_xor;
    logic [WIDTH-1:0]      w_result;
    logic                  w_err;

    // Stage 2 takes the stage-1 bundle whenever its own slot is empty or being
    // drained. Stage 1 can take a new bundle whenever it is empty or moving
    // forward, so bubbles collapse and one bundle per cycle is sustained.
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready   = !r_s1_valid || w_s2_load;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    assign out_valid  = r_s2_valid;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;

    // Fold AND/OR/XOR across every operand. The inverted ops invert the whole
    // fold result; they are not built by chaining the gate pairwise.
    always_comb begin
        w_and = r_s1_data[0 +: WIDTH];
        w_or  = r_s1_data[0 +: WIDTH];
        w_xor = r_s1_data[0 +: WIDTH];
        for (int k = 1; k < N_IN; k++) begin
            w_and = w_and & r_s1_data[k*WIDTH +: WIDTH];
            w_or  = w_or  | r_s1_data[k*WIDTH +: WIDTH];
            w_xor = w_xor ^ r_s1_data[k*WIDTH +: WIDTH];
        end
    end

    // Select the result for the stage-1 op. Reserved codes give 0 and raise err.
    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_s1_op)
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = w_or;
            OP_XOR:  w_result = w_xor;
            OP_NAND: w_result = ~w_and;
            OP_NOR:  w_result = ~w_or;
            OP_XNOR: w_result = ~w_xor;
            default: w_err    = 1'b1;
        endcase
    end

    // Stage 1 register: capture the operands and op on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_op    <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= in_data;
                r_s1_op    <= in_op;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 register: the result is held steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_out_data <= w_result;
                r_out_err  <= w_err;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic [15:0] r_stat_count;
    logic [15:0] r_stat_err;

    assign stat_count = r_stat_count;
    assign stat_err   = r_stat_err;

    // Count completed output transfers, and the ones that carried err.
    // Both counters wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_count <= '0;
            r_stat_err   <= '0;
        end else if (w_out_fire) begin
            r_stat_count <= r_stat_count + 16'd1;
            if (r_out_err)
                r_stat_err <= r_stat_err + 16'd1;
        end
    end
`endif

endmodule
